// File: rtl/dmem_if.sv
// Core-to-memory data bus: the core drives the request fields, the responder returns data.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, funct3, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, funct3, output rdata, ready, err);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM, RV32 load extension, alignment faults, wait states.
// Optional DMEM_MMIO_EN adds one 32-bit register at 0xFFFF_FF00 driven onto mmio_out.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_LAST   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FF00;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] rdata_reg;
  logic        ready_reg;
  logic        err_reg;

  logic                  idle;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [2:0]            acc_f3;
  logic                  go_resp;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic [3:0]            lane_we;
  logic [31:0]           wlanes;
  logic [31:0]           word_rd;
  logic [31:0]           src;
  logic [31:0]           shifted;
  logic [31:0]           load_val;
  logic                  mmio_hit;
  logic                  fault;

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_reg;
  assign mmio_out = mmio_reg;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:DEPTH_LOG2+2];
`endif

  // With zero wait states the access resolves in the accepting cycle, so the
  // live bus fields are used in IDLE and the latched copies afterwards.
  always_comb begin
    idle      = (state_reg == S_IDLE);
    acc_we    = idle ? bus.we     : we_reg;
    acc_addr  = idle ? bus.addr   : addr_reg;
    acc_wdata = idle ? bus.wdata  : wdata_reg;
    acc_f3    = idle ? bus.funct3 : funct3_reg;
    go_resp   = (idle && bus.req && (WAIT_STATES == 0)) ||
                (state_reg == S_WAIT && cnt_reg == WS_LAST);
    idx       = acc_addr[DEPTH_LOG2+1:2];
    wlanes    = acc_wdata << {acc_addr[1:0], 3'b000};
    case (acc_f3[1:0])
      2'b00:   be = 4'b0001 << acc_addr[1:0];
      2'b01:   be = acc_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
`ifdef DMEM_MMIO_EN
    mmio_hit = (acc_addr == MMIO_ADDR);
    src      = mmio_hit ? mmio_reg : word_rd;
`else
    mmio_hit = 1'b0;
    src      = word_rd;
`endif
    fault = (acc_f3 == 3'b011) || (acc_f3[2:1] == 2'b11) ||
            (acc_f3[1:0] == 2'b01 && acc_addr[0]) ||
            (acc_f3 == 3'b010 && acc_addr[1:0] != 2'b00) ||
            (acc_we && acc_f3[2:1] == 2'b10) ||
            (mmio_hit && acc_f3 != 3'b010);
    lane_we = (go_resp && acc_we && !fault && !mmio_hit && !rst) ? be : 4'b0000;
    shifted = src >> {acc_addr[1:0], 3'b000};
    case (acc_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // One narrow RAM per byte lane so partial stores need no read-modify-write.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (lane_we[gi]) mem[idx] <= wlanes[gi*8 +: 8];
    end
    assign word_rd[gi*8 +: 8] = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      funct3_reg <= 3'd0;
      rdata_reg  <= 32'd0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
`ifdef DMEM_MMIO_EN
      mmio_reg   <= 32'd0;
`endif
    end else begin
      ready_reg <= 1'b0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.req) begin
            we_reg     <= bus.we;
            addr_reg   <= bus.addr;
            wdata_reg  <= bus.wdata;
            funct3_reg <= bus.funct3;
            cnt_reg    <= 4'd0;
            state_reg  <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == WS_LAST) state_reg <= S_RESP;
        end
        default: state_reg <= S_IDLE;
      endcase
      if (go_resp) begin
        ready_reg <= 1'b1;
        err_reg   <= fault;
        rdata_reg <= (fault || acc_we) ? 32'd0 : load_val;
`ifdef DMEM_MMIO_EN
        if (mmio_hit && acc_we && !fault) mmio_reg <= acc_wdata;
`endif
      end
    end
  end

  assign bus.rdata = rdata_reg;
  assign bus.ready = ready_reg;
  assign bus.err   = err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one responder with one wait state, one with none.
module tb_dmem_responder;
  typedef struct packed {
    logic        chk;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   b0_start = 0;
  logic prev_ready0 = 1'b0;

  exp_t  sb1[$];
  exp_t  sb0[$];
  string tag1[$];
  string tag0[$];
  int    rdy_cyc0[$];

  dmem_if bus1();
  dmem_if bus0();
`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_out1;
  logic [31:0] mmio_out0;
`endif

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out1)
`endif
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out0)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t  e;
    string t;
    if (!rst) begin
      if (bus1.ready) begin
        if (sb1.size() == 0) check_eq("d1_spurious_ready", 32'd1, 32'd0);
        else begin
          e = sb1.pop_front();
          t = tag1.pop_front();
          check_eq({t, "_err"}, 32'(bus1.err), 32'(e.err));
          if (e.chk) check_eq({t, "_rdata"}, bus1.rdata, e.rdata);
        end
      end else begin
        check_eq("d1_idle_rdata", bus1.rdata, 32'd0);
        check_eq("d1_idle_err", 32'(bus1.err), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t  e;
    string t;
    if (!rst) begin
      if (bus0.ready) begin
        rdy_cyc0.push_back(cyc);
        if (prev_ready0) check_eq("d0_back_to_back_ready", 32'd1, 32'd0);
        if (sb0.size() == 0) check_eq("d0_spurious_ready", 32'd1, 32'd0);
        else begin
          e = sb0.pop_front();
          t = tag0.pop_front();
          check_eq({t, "_err"}, 32'(bus0.err), 32'(e.err));
          if (e.chk) check_eq({t, "_rdata"}, bus0.rdata, e.rdata);
        end
      end else begin
        check_eq("d0_idle_rdata", bus0.rdata, 32'd0);
      end
    end
    prev_ready0 = bus0.ready;
  end

  // One access on the one-wait-state responder; expected ready two cycles after the request cycle.
  task automatic do1(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic ee, input logic chk);
    int lat;
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = w; bus1.funct3 = f; bus1.addr = a; bus1.wdata = d;
    sb1.push_back('{chk, ee, er});
    tag1.push_back(tag);
    @(negedge clk);
    bus1.req = 1'b0;
    lat = 1;
    while (!bus1.ready && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd2);
    @(negedge clk);
    check_eq({tag, "_one_cycle"}, 32'(bus1.ready), 32'd0);
  endtask

  // Three accesses on the zero-wait responder with req held high throughout.
  task automatic burst0(input string tag, input logic w, input logic [2:0][2:0] f,
                        input logic [2:0][31:0] a, input logic [2:0][31:0] d,
                        input logic [2:0][31:0] er);
    @(negedge clk);
    b0_start = cyc;
    bus0.req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus0.we = w; bus0.funct3 = f[k]; bus0.addr = a[k]; bus0.wdata = d[k];
      sb0.push_back('{!w, 1'b0, er[k]});
      tag0.push_back($sformatf("%s_%0d", tag, k));
      @(negedge clk);
      @(negedge clk);
    end
    bus0.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 32'd0; bus1.wdata = 32'd0; bus1.funct3 = 3'd0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0; bus0.funct3 = 3'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ready1", 32'(bus1.ready), 32'd0);
    check_eq("rst_rdata1", bus1.rdata, 32'd0);
    check_eq("rst_err1", 32'(bus1.err), 32'd0);
    check_eq("rst_ready0", 32'(bus0.ready), 32'd0);
`ifdef DMEM_MMIO_EN
    check_eq("rst_mmio1", mmio_out1, 32'd0);
`endif
    rst = 1'b0;

    // Word store/load, then byte store into a known word and every load flavour.
    do1("sw10",     1'b1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    do1("lw10",     1'b0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
    do1("sw10b",    1'b1, F_W,  32'h10, 32'h11223344, 32'h0,        1'b0, 1'b0);
    do1("sb13",     1'b1, F_B,  32'h13, 32'h00000080, 32'h0,        1'b0, 1'b0);
    do1("lb13",     1'b0, F_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 1'b1);
    do1("lbu13",    1'b0, F_BU, 32'h13, 32'h0,        32'h00000080, 1'b0, 1'b1);
    do1("lw10c",    1'b0, F_W,  32'h10, 32'h0,        32'h80223344, 1'b0, 1'b1);
    do1("lb11",     1'b0, F_B,  32'h11, 32'h0,        32'h00000033, 1'b0, 1'b1);
    do1("lh12",     1'b0, F_H,  32'h12, 32'h0,        32'hFFFF8022, 1'b0, 1'b1);
    do1("lhu12",    1'b0, F_HU, 32'h12, 32'h0,        32'h00008022, 1'b0, 1'b1);

    // Faults: misalignment, reserved size, unsigned size on a store.
    do1("lh11",     1'b0, F_H,  32'h11, 32'h0,        32'h0,        1'b1, 1'b1);
    do1("sw12",     1'b1, F_W,  32'h12, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
    do1("lw10d",    1'b0, F_W,  32'h10, 32'h0,        32'h80223344, 1'b0, 1'b1);
    do1("sw14",     1'b1, F_W,  32'h14, 32'h01020304, 32'h0,        1'b0, 1'b0);
    do1("sh16",     1'b1, F_H,  32'h16, 32'h0000ABCD, 32'h0,        1'b0, 1'b0);
    do1("lw14",     1'b0, F_W,  32'h14, 32'h0,        32'hABCD0304, 1'b0, 1'b1);
    do1("lf3_011",  1'b0, 3'b011, 32'h14, 32'h0,      32'h0,        1'b1, 1'b1);
    do1("sbu14",    1'b1, F_BU, 32'h14, 32'h000000FF, 32'h0,        1'b1, 1'b0);
    do1("lw14b",    1'b0, F_W,  32'h14, 32'h0,        32'hABCD0304, 1'b0, 1'b1);
    do1("lw_alias", 1'b0, F_W,  32'h1010, 32'h0,      32'h80223344, 1'b0, 1'b1);

`ifdef DMEM_MMIO_EN
    do1("sw3f00",   1'b1, F_W,  32'h3F00, 32'hCAFEF00D, 32'h0,      1'b0, 1'b0);
    do1("sw_mmio",  1'b1, F_W,  32'hFFFFFF00, 32'h5,    32'h0,      1'b0, 1'b0);
    check_eq("mmio_out_after_sw", mmio_out1, 32'h5);
    do1("lw_mmio",  1'b0, F_W,  32'hFFFFFF00, 32'h0,    32'h5,      1'b0, 1'b1);
    do1("sb_mmio",  1'b1, F_B,  32'hFFFFFF00, 32'h7,    32'h0,      1'b1, 1'b0);
    do1("lh_mmio",  1'b0, F_H,  32'hFFFFFF00, 32'h0,    32'h0,      1'b1, 1'b1);
    check_eq("mmio_out_kept", mmio_out1, 32'h5);
    do1("lw3f00",   1'b0, F_W,  32'h3F00, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1);
`else
    do1("sw_ff00",  1'b1, F_W,  32'hFFFFFF00, 32'h5,    32'h0,      1'b0, 1'b0);
    do1("lw3f00",   1'b0, F_W,  32'h3F00, 32'h0,        32'h5,      1'b0, 1'b1);
`endif

    // Reset during the wait state of a store must abort it without writing.
    do1("sw20",     1'b1, F_W,  32'h20, 32'h11111111, 32'h0,        1'b0, 1'b0);
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.funct3 = F_W; bus1.addr = 32'h20; bus1.wdata = 32'h99999999;
    @(negedge clk);
    bus1.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do1("lw20",     1'b0, F_W,  32'h20, 32'h0,        32'h11111111, 1'b0, 1'b1);

    // Zero wait states, req held high: one response every second cycle.
    rdy_cyc0.delete();
    burst0("b0_sw", 1'b1, {F_W, F_W, F_W}, {32'h48, 32'h44, 32'h40},
           {32'h01020304, 32'hB1B2B3B4, 32'hA0A0A0A1}, {32'h0, 32'h0, 32'h0});
    repeat (3) @(negedge clk);
    check_eq("b0_ready_count", 32'(rdy_cyc0.size()), 32'd3);
    if (rdy_cyc0.size() == 3) begin
      check_eq("b0_ready_first", 32'(rdy_cyc0[0]), 32'(b0_start + 1));
      check_eq("b0_ready_gap1", 32'(rdy_cyc0[1] - rdy_cyc0[0]), 32'd2);
      check_eq("b0_ready_gap2", 32'(rdy_cyc0[2] - rdy_cyc0[1]), 32'd2);
    end
    burst0("b0_ld", 1'b0, {F_W, F_B, F_HU}, {32'h48, 32'h44, 32'h46},
           {32'h0, 32'h0, 32'h0}, {32'h01020304, 32'hFFFFFFB4, 32'h0000B1B2});
    repeat (3) @(negedge clk);

    check_eq("sb1_drained", 32'(sb1.size()), 32'd0);
    check_eq("sb0_drained", 32'(sb0.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
